// File: rtl/sk6812_rgbw_rx.sv
// sk6812_rgbw_rx: decodes an SK6812 RGBW pulse-width stream into indexed RGBW pixels.
module sk6812_rgbw_rx #(
  parameter int LEDS_NUM = 3,
  parameter int CLOCK_FRQ = 50_000_000,
  localparam int LED_ADDR_WIDTH = LEDS_NUM > 1 ? $clog2(LEDS_NUM) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ws_data,
  output logic [31:0]               color_rgbw,
  output logic                      color_valid,
  output logic [LED_ADDR_WIDTH-1:0] current_ledN,
  output logic                      frame_done,
  output logic                      error
);
  localparam int BIT_CYCLES = CLOCK_FRQ / 800_000;
  localparam int THRESH_CYCLES = BIT_CYCLES / 2;
  localparam int MIN_PULSE = BIT_CYCLES / 8;
  localparam int MAX_HIGH = 2 * BIT_CYCLES;
  localparam int LATCH_CYCLES = 40 * BIT_CYCLES;
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int IW = $clog2(LEDS_NUM + 1);

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  state_t state;
  logic s0, s1, s2, rise, fall, active;
  logic [LW-1:0] lcnt;
  logic [HW-1:0] hcnt;
  logic [4:0] bcnt;
  logic [30:0] sh;
  logic [IW-1:0] idx;
  logic bit_v;
  logic [31:0] word;

  assign bit_v = hcnt >= HW'(THRESH_CYCLES);
  assign word = {sh, bit_v};

  // edge pulses are registered so the FSM sees them one clock after the synchronizer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      state <= SYNC;
      lcnt <= '0;
      hcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      idx <= '0;
      active <= 1'b0;
      color_rgbw <= '0;
      color_valid <= 1'b0;
      current_ledN <= '0;
      frame_done <= 1'b0;
      error <= 1'b0;
    end else begin
      s0 <= ws_data;
      s1 <= s0;
      s2 <= s1;
      rise <= s1 & ~s2;
      fall <= ~s1 & s2;
      color_valid <= 1'b0;
      frame_done <= 1'b0;
      error <= 1'b0;
      case (state)
        SYNC: begin
          if (s2) lcnt <= '0;
          else if (lcnt == LW'(LATCH_CYCLES - 1)) begin
            lcnt <= LW'(LATCH_CYCLES);
            state <= LOW;
          end else lcnt <= lcnt + 1'b1;
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            hcnt <= HW'(1);
          end else if (lcnt == LW'(LATCH_CYCLES - 1)) begin
            lcnt <= LW'(LATCH_CYCLES);
            frame_done <= active;
            error <= bcnt != 5'd0;
            bcnt <= '0;
            idx <= '0;
            active <= 1'b0;
          end else if (lcnt != LW'(LATCH_CYCLES)) lcnt <= lcnt + 1'b1;
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
            // glitches keep the accumulated low time so they cannot postpone a latch
            if (hcnt >= HW'(MIN_PULSE)) begin
              lcnt <= '0;
              sh <= word[30:0];
              bcnt <= bcnt + 1'b1;
              active <= 1'b1;
              if (bcnt == 5'd31 && idx < IW'(LEDS_NUM)) begin
                color_rgbw <= {word[7:0], word[15:8], word[31:24], word[23:16]};
                current_ledN <= idx[LED_ADDR_WIDTH-1:0];
                color_valid <= 1'b1;
                idx <= idx + 1'b1;
              end
            end
          end else if (hcnt == HW'(MAX_HIGH)) begin
            error <= 1'b1;
            bcnt <= '0;
            idx <= '0;
            active <= 1'b0;
            lcnt <= '0;
            state <= SYNC;
          end else hcnt <= hcnt + 1'b1;
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_sk6812_rgbw_rx.sv
// tb_sk6812_rgbw_rx: randomized scoreboard bench for the SK6812 RGBW receiver.
module tb_sk6812_rgbw_rx;
  localparam int LEDS = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ws_data = 1'b0;
  logic [31:0] color_rgbw;
  logic color_valid;
  logic [1:0] current_ledN;
  logic frame_done;
  logic error;

  sk6812_rgbw_rx #(.LEDS_NUM(LEDS), .CLOCK_FRQ(50_000_000)) dut (
    .clock(clock),
    .reset(reset),
    .ws_data(ws_data),
    .color_rgbw(color_rgbw),
    .color_valid(color_valid),
    .current_ledN(current_ledN),
    .frame_done(frame_done),
    .error(error)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {logic [31:0] rgbw; int idx;} pix_t;
  typedef struct {bit fd; bit err; int at;} ev_t;
  pix_t pq[$];
  ev_t eq[$];
  int vectors = 0;
  int miscompares = 0;
  int last_fall = 0;
  int m_idx = 0;
  int m_bits = 0;
  bit m_active = 1'b0;
  bit m_sync = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every strobe from the DUT must match the head of a scoreboard queue
  always @(negedge clock) begin
    pix_t p;
    ev_t e;
    if (reset) begin
      if (color_valid) begin
        if (pq.size() == 0) check("unexpected color_valid", 64'd1, 64'd0);
        else begin
          p = pq.pop_front();
          check("color_rgbw", color_rgbw, p.rgbw);
          check("current_ledN", current_ledN, p.idx);
          check("valid latency", cyc - last_fall, 4);
        end
      end
      if (frame_done || error) begin
        if (eq.size() == 0) check("unexpected frame_done/error", {frame_done, error}, 0);
        else begin
          e = eq.pop_front();
          check("frame_done", frame_done, e.fd);
          check("error", error, e.err);
          if (e.at >= 0) check("frame_done cycle", cyc, e.at);
        end
      end
      if (frame_done && color_valid) check("valid with frame_done", 64'd1, 64'd0);
    end
  end

  task automatic hold(input logic v, input int n);
    ws_data = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int rand_h(input bit b);
    int r;
    r = $urandom_range(0, 9);
    if (b) return r == 0 ? 31 : r == 1 ? 123 : $urandom_range(41, 71);
    return r == 0 ? 7 : r == 1 ? 30 : $urandom_range(16, 28);
  endfunction

  task automatic send_bit(input bit b);
    int h;
    h = rand_h(b);
    hold(1'b1, h);
    ws_data = 1'b0;
    last_fall = cyc;
    hold(1'b0, 63 - h < 8 ? 8 : 63 - h);
    if (!m_sync) begin
      m_bits = (m_bits + 1) % 32;
      m_active = 1'b1;
    end
  endtask

  // the argument is the RGBW word the receiver must report; the wire carries G,R,B,W
  task automatic send_pixel(input logic [31:0] rgbw, input bit glitch);
    logic [31:0] w;
    w = {rgbw[15:8], rgbw[7:0], rgbw[23:16], rgbw[31:24]};
    if (!m_sync && m_idx < LEDS) begin
      pq.push_back('{rgbw, m_idx});
      m_idx++;
    end
    for (int i = 31; i >= 0; i--) begin
      if (glitch) begin
        hold(1'b1, 5);
        hold(1'b0, 15);
      end
      send_bit(w[i]);
    end
  endtask

  task automatic latch(input int n);
    if (m_sync) m_sync = 1'b0;
    else if (m_active) eq.push_back('{1'b1, m_bits != 0, last_fall + 2484});
    m_idx = 0;
    m_bits = 0;
    m_active = 1'b0;
    hold(1'b0, n);
  endtask

  task automatic stuck();
    eq.push_back('{1'b0, 1'b1, -1});
    m_sync = 1'b1;
    m_idx = 0;
    m_bits = 0;
    m_active = 1'b0;
    hold(1'b1, 130);
    ws_data = 1'b0;
    last_fall = cyc;
    hold(1'b0, 20);
  endtask

  initial begin
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("reset color_rgbw", color_rgbw, 0);
    check("reset color_valid", color_valid, 0);
    check("reset current_ledN", current_ledN, 0);
    check("reset frame_done", frame_done, 0);
    check("reset error", error, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    latch(3000);
    send_pixel(32'h78563412, 1'b0);
    latch(2500);
    send_pixel(32'hFF000000, 1'b0);
    send_pixel(32'h00FF0000, 1'b0);
    send_pixel(32'h000000FF, 1'b0);
    latch(2500);
    for (int i = 0; i < 5; i++) send_pixel($urandom, 1'b0);
    latch(2500);
    check("ledN holds last index", current_ledN, LEDS - 1);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom));
    latch(2500);
    send_pixel($urandom, 1'b0);
    latch(2500);
    send_pixel(32'hA5A5A5A5, 1'b1);
    latch(2500);
    stuck();
    send_pixel($urandom, 1'b0);
    latch(2500);
    send_pixel($urandom, 1'b0);
    latch(2500);
    send_pixel($urandom, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid reset color_rgbw", color_rgbw, 0);
    check("mid reset current_ledN", current_ledN, 0);
    m_sync = 1'b1;
    m_idx = 0;
    m_bits = 0;
    m_active = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 22; i++) send_bit(1'($urandom));
    send_pixel($urandom, 1'b0);
    latch(2500);
    send_pixel($urandom, 1'b0);
    latch(2500);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) send_pixel($urandom, 1'b0);
      latch(2500);
    end
    hold(1'b0, 20);
    check("pending pixels", pq.size(), 0);
    check("pending events", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
